// File: rtl/cvm300_capture_sequencer.sv
// One CVM300 capture: sensor reset, FIFO reset, settle, FRAME_REQ pulse, then LVAL line counting to completion or timeout.
// All outputs are registered from the next state, so they follow a command by one cycle; no flow control.
module cvm300_capture_sequencer #(
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int FIFO_RST_CYCLES   = 4,
    parameter int SETTLE_CYCLES     = 4095,
    parameter int FRAME_REQ_WIDTH   = 1,
    parameter int LINES_PER_FRAME   = 488,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic        FSM_Clk,
    input  logic        reset,
    input  logic        sensor_rst_req,
    input  logic        grab_req,
    input  logic        continuous,
    input  logic        abort,
    input  logic        lval,
    output logic        sys_res_n,
    output logic        fifo_reset,
    output logic        frame_req,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [15:0] frame_count,
    output logic [9:0]  line_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SENSOR_RST = 3'd1,
        ST_FIFO_RST   = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_FRAME_REQ  = 3'd4,
        ST_WAIT_LINES = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    localparam int M1      = (RESET_HOLD_CYCLES > FIFO_RST_CYCLES) ? RESET_HOLD_CYCLES : FIFO_RST_CYCLES;
    localparam int M2      = (M1 > SETTLE_CYCLES) ? M1 : SETTLE_CYCLES;
    localparam int M3      = (M2 > FRAME_REQ_WIDTH) ? M2 : FRAME_REQ_WIDTH;
    localparam int CNT_MAX = (M3 > TIMEOUT_CYCLES) ? M3 : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RH_LAST     = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FR_LAST     = CNT_W'(FIFO_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SC_LAST     = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FW_LAST     = CNT_W'(FRAME_REQ_WIDTH - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]       LINES_FRAME = 10'(LINES_PER_FRAME);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [9:0]         r_line_count;
    logic [9:0]         w_line_nxt;
    logic [9:0]         w_line_inc;
    logic [15:0]        r_frame_count;
    logic [15:0]        w_frame_nxt;
    logic               r_timeout_err;
    logic               w_terr_nxt;
    logic               r_grab_q;
    logic               r_lval_q;
    logic               w_grab_rise;
    logic               w_lval_rise;
    logic               r_sys_res_n;
    logic               r_fifo_reset;
    logic               r_frame_req;
    logic               r_busy;
    logic               r_frame_done;

    assign w_grab_rise = grab_req & ~r_grab_q;
    assign w_lval_rise = lval & ~r_lval_q;
    assign w_line_inc  = r_line_count + 10'd1;

    // Edge history tracks the inputs even during reset, so a level held high across reset is not an edge.
    always_ff @(posedge FSM_Clk) begin
        r_grab_q <= grab_req;
        r_lval_q <= lval;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_line_nxt  = r_line_count;
        w_frame_nxt = r_frame_count;
        w_terr_nxt  = r_timeout_err;
        if (sensor_rst_req) begin
            w_state_nxt = ST_SENSOR_RST;
            w_cnt_nxt   = '0;
        end else if (abort && (r_state != ST_IDLE) && (r_state != ST_SENSOR_RST)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grab_rise) begin
                        w_state_nxt = ST_FIFO_RST;
                        w_cnt_nxt   = '0;
                        w_terr_nxt  = 1'b0;
                        w_line_nxt  = '0;
                    end
                end
                ST_SENSOR_RST: begin
                    if (r_cnt == RH_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_FIFO_RST: begin
                    if (r_cnt == FR_LAST) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == SC_LAST) begin
                        w_state_nxt = ST_FRAME_REQ;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_FRAME_REQ: begin
                    if (r_cnt == FW_LAST) begin
                        w_state_nxt = ST_WAIT_LINES;
                        w_cnt_nxt   = '0;
                        w_line_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_WAIT_LINES: begin
                    // A completing edge in the timeout cycle still finishes the frame.
                    if (w_lval_rise && (w_line_inc == LINES_FRAME)) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = '0;
                        w_line_nxt  = w_line_inc;
                        w_frame_nxt = r_frame_count + 16'd1;
                    end else begin
                        if (w_lval_rise) begin
                            w_line_nxt = w_line_inc;
                        end
                        if (r_cnt == TO_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                            w_terr_nxt  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = continuous ? ST_SETTLE : ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge FSM_Clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_line_count  <= '0;
            r_frame_count <= '0;
            r_timeout_err <= 1'b0;
            r_sys_res_n   <= 1'b1;
            r_fifo_reset  <= 1'b0;
            r_frame_req   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_line_count  <= w_line_nxt;
            r_frame_count <= w_frame_nxt;
            r_timeout_err <= w_terr_nxt;
            r_sys_res_n   <= (w_state_nxt != ST_SENSOR_RST);
            r_fifo_reset  <= (w_state_nxt == ST_FIFO_RST);
            r_frame_req   <= (w_state_nxt == ST_FRAME_REQ);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_frame_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign sys_res_n   = r_sys_res_n;
    assign fifo_reset  = r_fifo_reset;
    assign frame_req   = r_frame_req;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout_err;
    assign frame_count = r_frame_count;
    assign line_count  = r_line_count;
    assign state       = r_state;

endmodule

// File: tb/tb_cvm300_capture_sequencer.sv
// Bench for cvm300_capture_sequencer: directed scenarios with literal expectations plus random stimulus,
// every cycle compared against a countdown-based phase model of the capture sequence.
module tb_cvm300_capture_sequencer;

    localparam int RH  = 2;
    localparam int FR  = 2;
    localparam int SC  = 3;
    localparam int FW  = 1;
    localparam int LPF = 4;
    localparam int TO  = 50;

    logic        FSM_Clk = 1'b0;
    logic        reset = 1'b1;
    logic        sensor_rst_req = 1'b0;
    logic        grab_req = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic        lval = 1'b0;
    logic        sys_res_n;
    logic        fifo_reset;
    logic        frame_req;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;
    logic [15:0] frame_count;
    logic [9:0]  line_count;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit preload = 1'b0;

    cvm300_capture_sequencer #(
        .RESET_HOLD_CYCLES(RH),
        .FIFO_RST_CYCLES  (FR),
        .SETTLE_CYCLES    (SC),
        .FRAME_REQ_WIDTH  (FW),
        .LINES_PER_FRAME  (LPF),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .FSM_Clk       (FSM_Clk),
        .reset         (reset),
        .sensor_rst_req(sensor_rst_req),
        .grab_req      (grab_req),
        .continuous    (continuous),
        .abort         (abort),
        .lval          (lval),
        .sys_res_n     (sys_res_n),
        .fifo_reset    (fifo_reset),
        .frame_req     (frame_req),
        .busy          (busy),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err),
        .frame_count   (frame_count),
        .line_count    (line_count),
        .state         (state)
    );

    always #5 FSM_Clk = ~FSM_Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge FSM_Clk);
            #2;
        end
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (state !== 3'(s) && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_state", 32'(state), 32'(s));
    endtask

    // Reference model: phase number plus "cycles left in this phase" countdowns.
    int m_ph = 0;
    int m_left = 0;
    int m_tleft = 0;
    int m_lines = 0;
    int m_frames = 0;
    bit m_terr = 1'b0;
    bit m_gprev = 1'b0;
    bit m_lprev = 1'b0;
    bit m_gr;
    bit m_lr;

    always @(posedge FSM_Clk) begin
        m_gr = grab_req && !m_gprev;
        m_lr = lval && !m_lprev;
        m_gprev = grab_req;
        m_lprev = lval;
        if (preload) m_frames = 65535;
        if (reset) begin
            m_ph = 0; m_lines = 0; m_frames = 0; m_terr = 1'b0;
        end else if (sensor_rst_req) begin
            m_ph = 1; m_left = RH;
        end else if (abort && m_ph != 0 && m_ph != 1) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (m_gr) begin
                    m_ph = 2; m_left = FR; m_terr = 1'b0; m_lines = 0;
                end
                1, 2, 3, 4: begin
                    m_left--;
                    if (m_left == 0) begin
                        case (m_ph)
                            1: m_ph = 0;
                            2: begin m_ph = 3; m_left = SC; end
                            3: begin m_ph = 4; m_left = FW; end
                            default: begin m_ph = 5; m_lines = 0; m_tleft = TO; end
                        endcase
                    end
                end
                5: begin
                    if (m_lr) m_lines++;
                    if (m_lr && m_lines == LPF) begin
                        m_ph = 6; m_frames = (m_frames + 1) % 65536;
                    end else begin
                        m_tleft--;
                        if (m_tleft == 0) begin m_terr = 1'b1; m_ph = 0; end
                    end
                end
                default: begin
                    if (continuous) begin m_ph = 3; m_left = SC; end
                    else m_ph = 0;
                end
            endcase
        end
    end

    always @(negedge FSM_Clk) begin
        if (chk_en) begin
            check("state",       32'(state),       32'(m_ph));
            check("sys_res_n",   32'(sys_res_n),   32'(m_ph != 1));
            check("fifo_reset",  32'(fifo_reset),  32'(m_ph == 2));
            check("frame_req",   32'(frame_req),   32'(m_ph == 4));
            check("busy",        32'(busy),        32'(m_ph != 0));
            check("frame_done",  32'(frame_done),  32'(m_ph == 6));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
            check("frame_count", 32'(frame_count), 32'(m_frames));
            check("line_count",  32'(line_count),  32'(m_lines));
        end
    end

    // Free-running activity counters; directed checks look at their deltas.
    int c_sys_low = 0, c_busy = 0, c_fifo = 0, c_fifo_rise = 0, c_settle = 0;
    int c_freq = 0, c_done = 0, c_wait = 0;
    logic p_fifo = 1'b0;

    always @(negedge FSM_Clk) begin
        if (sys_res_n === 1'b0) c_sys_low++;
        if (busy === 1'b1) c_busy++;
        if (fifo_reset === 1'b1) c_fifo++;
        if (fifo_reset === 1'b1 && p_fifo !== 1'b1) c_fifo_rise++;
        if (state === 3'd3) c_settle++;
        if (frame_req === 1'b1) c_freq++;
        if (frame_done === 1'b1) c_done++;
        if (state === 3'd5) c_wait++;
        p_fifo = fifo_reset;
    end

    task automatic lval_pulses(input int n, input int spacing, input bit chk_lines);
        for (int i = 0; i < n; i++) begin
            lval = 1'b1;
            tick(1);
            if (chk_lines) check("line_count_step", 32'(line_count), 32'(i + 1));
            lval = 1'b0;
            tick(spacing - 1);
        end
    endtask

    initial begin
        int s_sys, s_busy, s_fifo, s_fifo_rise, s_settle, s_freq, s_done, s_wait;

        tick(1);
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;
        check("reset_state", 32'(state), 32'd0);
        check("reset_sys_res_n", 32'(sys_res_n), 32'd1);
        check("reset_frame_count", 32'(frame_count), 32'd0);
        tick(2);

        // Sensor reset sequence.
        s_sys = c_sys_low; s_busy = c_busy;
        sensor_rst_req = 1'b1;
        tick(1);
        sensor_rst_req = 1'b0;
        tick(5);
        check("sensor_rst_low_cycles", 32'(c_sys_low - s_sys), 32'd2);
        check("sensor_rst_busy_cycles", 32'(c_busy - s_busy), 32'd2);
        check("sensor_rst_end_state", 32'(state), 32'd0);

        // Single frame.
        s_fifo = c_fifo; s_settle = c_settle; s_freq = c_freq; s_done = c_done;
        grab_req = 1'b1;
        tick(1);
        wait_state(5, 40);
        lval_pulses(4, 5, 1'b1);
        tick(3);
        grab_req = 1'b0;
        check("single_fifo_cycles", 32'(c_fifo - s_fifo), 32'd2);
        check("single_settle_cycles", 32'(c_settle - s_settle), 32'd3);
        check("single_frame_req_cycles", 32'(c_freq - s_freq), 32'd1);
        check("single_frame_done", 32'(c_done - s_done), 32'd1);
        check("single_frame_count", 32'(frame_count), 32'd1);
        check("single_end_state", 32'(state), 32'd0);

        // Continuous: three frames behind a single FIFO reset.
        s_fifo_rise = c_fifo_rise; s_settle = c_settle; s_freq = c_freq; s_done = c_done;
        continuous = 1'b1;
        tick(1);
        grab_req = 1'b1;
        tick(1);
        for (int f = 0; f < 3; f++) begin
            wait_state(5, 40);
            lval_pulses(3, 2, 1'b0);
            lval = 1'b1;
            tick(1);
            if (f == 2) continuous = 1'b0;
            lval = 1'b0;
            tick(2);
        end
        tick(4);
        grab_req = 1'b0;
        check("cont_frame_count", 32'(frame_count), 32'd4);
        check("cont_fifo_resets", 32'(c_fifo_rise - s_fifo_rise), 32'd1);
        check("cont_settle_cycles", 32'(c_settle - s_settle), 32'd9);
        check("cont_frame_reqs", 32'(c_freq - s_freq), 32'd3);
        check("cont_frame_done", 32'(c_done - s_done), 32'd3);
        check("cont_end_state", 32'(state), 32'd0);

        // Timeout with only two lines.
        tick(1);
        grab_req = 1'b1;
        tick(1);
        wait_state(5, 40);
        s_wait = c_wait;
        lval_pulses(2, 5, 1'b0);
        tick(45);
        check("timeout_wait_cycles", 32'(c_wait - s_wait), 32'd50);
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        check("timeout_frame_count", 32'(frame_count), 32'd4);
        grab_req = 1'b0;
        tick(1);
        grab_req = 1'b1;
        tick(1);
        check("timeout_err_cleared", 32'(timeout_err), 32'd0);

        // Abort during SETTLE.
        wait_state(3, 20);
        s_freq = c_freq;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick(10);
        check("abort_no_frame_req", 32'(c_freq - s_freq), 32'd0);

        // sensor_rst_req beats abort in WAIT_LINES.
        grab_req = 1'b0;
        tick(1);
        grab_req = 1'b1;
        tick(1);
        wait_state(5, 30);
        sensor_rst_req = 1'b1;
        abort = 1'b1;
        tick(1);
        sensor_rst_req = 1'b0;
        abort = 1'b0;
        check("rst_beats_abort_state", 32'(state), 32'd1);
        check("rst_beats_abort_sys", 32'(sys_res_n), 32'd0);
        tick(4);

        // grab_req held high through reset.
        grab_req = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        grab_req = 1'b1;
        tick(2);
        reset = 1'b0;
        s_busy = c_busy;
        tick(6);
        check("held_grab_no_start", 32'(c_busy - s_busy), 32'd0);
        check("held_grab_frame_count", 32'(frame_count), 32'd0);
        grab_req = 1'b0;
        tick(2);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            sensor_rst_req = ($urandom_range(0, 199) == 0);
            abort = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 29) == 0) grab_req = ~grab_req;
            if ($urandom_range(0, 99) == 0) continuous = ~continuous;
            lval = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        sensor_rst_req = 1'b0; abort = 1'b0; grab_req = 1'b0;
        continuous = 1'b0; lval = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);

        // frame_count wrap from 0xFFFF.
        chk_en = 1'b0;
        force dut.r_frame_count = 16'hFFFF;
        preload = 1'b1;
        tick(1);
        preload = 1'b0;
        release dut.r_frame_count;
        tick(1);
        chk_en = 1'b1;
        check("preload_frame_count", 32'(frame_count), 32'd65535);
        s_done = c_done;
        grab_req = 1'b1;
        tick(1);
        wait_state(5, 40);
        lval_pulses(4, 3, 1'b0);
        tick(3);
        grab_req = 1'b0;
        check("wrap_frame_done", 32'(c_done - s_done), 32'd1);
        check("wrap_frame_count", 32'(frame_count), 32'd0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
